cpu_wb_bridge: RTL and testbench
================================

// Module: cpu_wb_bridge
// PURPOSE
//  Downstream of the 68040 bus interface: takes its request/write/read channels and runs them as
//  Wishbone classic master cycles to the SoC fabric. Single transfers (len 1) and line bursts (len 4).
//  Buffers CPU write beats (no backpressure on write_valid) and returned read beats (held until read_ack).
// PARAMETERS
//  FIFO_DEPTH   4     entries in each of write FIFO and read FIFO; power of 2, >= 4
//  TIMEOUT_CYC  255   watchdog limit in cycles per beat (used only with BRIDGE_TIMEOUT_EN)
// PORTS
//  clk_i        in   1   system clock
//  rst_i        in   1   synchronous active-high reset
//  req_valid    in   1   request offered
//  req_ready    out  1   request accepted when req_valid & req_ready
//  req_len      in   3   beats: 1 or 4
//  req_mask     in   4   byte lanes, [3] = byte at addr+0
//  req_addr     in   32  byte address
//  req_we       in   1   1 = write
//  write_valid  in   1   one-cycle write beat strobe
//  write_data   in   32  write beat data
//  read_valid   out  1   read FIFO not empty
//  read_data    out  32  read FIFO head
//  read_ack     in   1   pop when read_valid & read_ack
//  wb_cyc_o     out  1   Wishbone cycle
//  wb_stb_o     out  1   Wishbone strobe
//  wb_we_o      out  1   Wishbone write enable
//  wb_adr_o     out  30  word address (byte addr [31:2])
//  wb_sel_o     out  4   byte selects
//  wb_dat_o     out  32  write data
//  wb_dat_i     in   32  read data
//  wb_ack_i     in   1   beat acknowledge
//  wb_err_i     in   1   beat error termination
//  bus_err_o    out  1   one-cycle pulse per errored beat or write FIFO overflow
// BEHAVIOUR
//  Reset: req_ready=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_sel_o=0, bus_err_o=0, both FIFOs
//   empty (read_valid=0). Reset mid-burst aborts it: cyc/stb drop next edge, FIFO contents discarded.
//  All outputs registered except read_valid/read_data/wb_dat_o (FIFO head, combinational from regs).
//  FSM IDLE -> RD | WR -> IDLE.
//   IDLE: req_ready=1 (first cycle after reset release onward). On accept: latch addr, we, beat count
//    = req_len, sel = req_mask (len 1) or 4'hF (len 4); req_ready<=0; enter RD if !req_we else WR.
//    req_len values other than 1/4 treated as 1.
//   RD: stb asserted only while read FIFO free slots > 0; on ack push wb_dat_i, on err push 32'hFFFFFFFF
//    and pulse bus_err_o. Beat completes on ack|err (ack wins if both).
//   WR: stb asserted only while write FIFO non-empty; wb_dat_o = FIFO head; pop on ack|err.
//  Per beat: complete -> count-1, adr[1:0] (word-in-line, byte addr[3:2]) +1 mod 4, upper bits fixed
//   (line wrap: start 0x...8 -> 8,C,0,4). stb may stay high into the next beat the edge after ack.
//  Last beat complete: cyc, stb deassert next edge; state IDLE; req_ready=1 that same edge.
//  cyc asserted for whole request, including cycles where stb is low waiting for FIFO data/space.
//  Write FIFO accepts write_valid in any state. Push when full: beat dropped, bus_err_o pulse.
//  Push and pop same cycle on full FIFO: both occur, no overflow. Pop on read_ack with read_valid=0: ignored.
//  Simultaneous read push and read_ack pop: both occur, count unchanged.
// CONFIGURATION
//  BRIDGE_TIMEOUT_EN defined: per-beat counter clears on every beat completion/stb rise; if stb high
//   TIMEOUT_CYC cycles without ack|err, beat is force-completed as err (read pushes 32'hFFFFFFFF, write
//   pops data), bus_err_o pulses, burst continues.
//  Not defined: no counter; a missing ack stalls forever.
// TESTING
//  Read len1 addr 0x00001004 mask 4'b1100, slave ack after 2 cycles data 0x12345678 -> adr 0x401,
//   sel 4'b1100, read_valid with 0x12345678, req_ready back high after cyc drop.
//  Read len4 addr 0x20000008, read_ack held 0 -> adr low bits 2,3,0,1, four entries, 5th never requested;
//   ack pops in order.
//  Write len4 addr 0x100, write_valid beats 1,2,3,4 spaced 3 cycles -> stb low while FIFO empty, cyc held,
//   wb_dat_o 1..4, sel 4'hF.
//  wb_err_i on beat 2 of a read burst -> 2nd entry 0xFFFFFFFF, one bus_err_o pulse, beats 3-4 still run.
//  Five write_valid pulses with no WB ack, depth 4 -> 5th dropped, bus_err_o pulse.
//  With BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks -> beat ends after 8 stb cycles, 0xFFFFFFFF read.

Source files
------------

// File: rtl/cpu_wb_bridge.sv
// cpu_wb_bridge: runs 68040-side request/write/read channels as Wishbone classic master cycles.
// Optional per-beat watchdog is compiled in when BRIDGE_TIMEOUT_EN is defined.
module cpu_wb_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_len,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        write_valid,
  input  logic [31:0] write_data,
  output logic        read_valid,
  output logic [31:0] read_data,
  input  logic        read_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t        r_state;
  logic          r_req_ready, r_cyc, r_stb, r_we, r_bus_err;
  logic [29:0]   r_adr;
  logic [3:0]    r_sel;
  logic [2:0]    r_beats;

  logic [31:0]   r_wf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wf_wp, r_wf_rp;
  logic [CW-1:0] r_wf_cnt;
  logic [31:0]   r_rf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rf_wp, r_rf_rp;
  logic [CW-1:0] r_rf_cnt;

  logic          w_timeout, w_beat_done, w_beat_err, w_last, w_accept;
  logic          w_wf_full, w_wf_push, w_wf_pop, w_wf_ovf;
  logic          w_rf_push, w_rf_pop;
  logic [CW-1:0] w_wf_cnt_next, w_rf_cnt_next;
  logic [31:0]   w_rf_din;
  logic          w_unused;

  // A beat can only complete while stb is high; ack takes priority over err.
  assign w_beat_done = r_stb & (wb_ack_i | wb_err_i | w_timeout);
  assign w_beat_err  = r_stb & ~wb_ack_i & (wb_err_i | w_timeout);
  assign w_last      = w_beat_done & (r_beats == 3'd1);
  assign w_accept    = (r_state == S_IDLE) & r_req_ready & req_valid;

  assign w_wf_full     = (r_wf_cnt == CW'(FIFO_DEPTH));
  assign w_wf_pop      = w_beat_done & (r_state == S_WR);
  assign w_wf_push     = write_valid & (~w_wf_full | w_wf_pop);
  assign w_wf_ovf      = write_valid & w_wf_full & ~w_wf_pop;
  assign w_wf_cnt_next = r_wf_cnt + CW'(w_wf_push) - CW'(w_wf_pop);

  assign w_rf_push     = w_beat_done & (r_state == S_RD);
  assign w_rf_pop      = read_ack & (r_rf_cnt != '0);
  assign w_rf_cnt_next = r_rf_cnt + CW'(w_rf_push) - CW'(w_rf_pop);
  assign w_rf_din      = wb_ack_i ? wb_dat_i : 32'hFFFF_FFFF;

  assign w_unused = &{1'b0, req_addr[1:0], 1'(TIMEOUT_CYC)};

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  // Counts stb-high cycles of the current beat; zero on the first stb cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !r_stb || w_beat_done) r_to_cnt <= '0;
    else                                r_to_cnt <= r_to_cnt + TW'(1);
  end
  assign w_timeout = r_stb & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (w_wf_push) r_wf_mem[r_wf_wp] <= write_data;
    if (w_rf_push) r_rf_mem[r_rf_wp] <= w_rf_din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wf_wp <= '0; r_wf_rp <= '0; r_wf_cnt <= '0;
      r_rf_wp <= '0; r_rf_rp <= '0; r_rf_cnt <= '0;
    end else begin
      if (w_wf_push) r_wf_wp <= r_wf_wp + AW'(1);
      if (w_wf_pop)  r_wf_rp <= r_wf_rp + AW'(1);
      if (w_rf_push) r_rf_wp <= r_rf_wp + AW'(1);
      if (w_rf_pop)  r_rf_rp <= r_rf_rp + AW'(1);
      r_wf_cnt <= w_wf_cnt_next;
      r_rf_cnt <= w_rf_cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_beats     <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= w_beat_err | w_wf_ovf;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_adr       <= req_addr[31:2];
            r_we        <= req_we;
            r_beats     <= (req_len == 3'd4) ? 3'd4 : 3'd1;
            r_sel       <= (req_len == 3'd4) ? 4'hF : req_mask;
            if (req_we) begin
              r_state <= S_WR;
              r_stb   <= (w_wf_cnt_next != '0);
            end else begin
              r_state <= S_RD;
              r_stb   <= (w_rf_cnt_next != CW'(FIFO_DEPTH));
            end
          end
        end
        default: begin
          // Only the word-in-line bits advance, giving the 68040 line-wrap order.
          if (w_beat_done) begin
            r_beats    <= r_beats - 3'd1;
            r_adr[1:0] <= r_adr[1:0] + 2'd1;
          end
          if (w_last) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_req_ready <= 1'b1;
          end else if (r_state == S_WR) begin
            r_stb <= (w_wf_cnt_next != '0);
          end else begin
            r_stb <= (w_rf_cnt_next != CW'(FIFO_DEPTH));
          end
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_adr_o   = r_adr;
  assign wb_sel_o   = r_sel;
  assign wb_dat_o   = r_wf_mem[r_wf_rp];
  assign bus_err_o  = r_bus_err;
  assign read_valid = (r_rf_cnt != '0);
  assign read_data  = r_rf_mem[r_rf_rp];
endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Randomised scoreboard bench for cpu_wb_bridge: requests push expected beats, a monitor pops/compares.
// Define BRIDGE_TIMEOUT_EN to also exercise the watchdog (instance uses TIMEOUT_CYC=8).
`timescale 1ns/1ps
module tb_cpu_wb_bridge;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, write_valid = 1'b0, read_ack = 1'b0;
  logic [2:0]  req_len = 3'd1;
  logic [3:0]  req_mask = 4'h0;
  logic [31:0] req_addr = '0, write_data = '0, wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic        req_ready, read_valid, wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o;
  logic [31:0] read_data, wb_dat_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;

  always #5 clk_i = ~clk_i;

  cpu_wb_bridge #(.FIFO_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr), .req_we(req_we),
    .write_valid(write_valid), .write_data(write_data), .read_valid(read_valid),
    .read_data(read_data), .read_ack(read_ack), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic [29:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  int checks = 0, failures = 0;
  int exp_berr_total = 0, seen_berr_total = 0;
  int ack_mode = 1;        // 0: hold read_ack low, 1: always ack, 2: random
  int slave_mute = 0, slave_delay = -1, slave_err_pct = 0, slave_err_beat = -1;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_ready(input int max);
    int k = 0;
    @(negedge clk_i);
    while (!req_ready && k < max) begin
      @(negedge clk_i);
      k++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL wait_req_ready actual=0 required=1 (cycle budget expired)");
    end
  endtask

  // Expected beats come straight from the request: word address wraps within a 4-word line.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] len,
                        input logic [3:0] mask, input int gap, input bit send_data,
                        input logic [31:0] pre [4]);
    int n;
    logic [31:0] wd [4];
    logic [29:0] word;
    beat_t b;
    n = (len == 3'd4) ? 4 : 1;
    word = addr[31:2];
    for (int i = 0; i < 4; i++) wd[i] = send_data ? $urandom : pre[i];
    for (int i = 0; i < n; i++) begin
      b.adr = (word & ~30'd3) | ((word + 30'(i)) & 30'd3);
      b.sel = (n == 4) ? 4'hF : mask;
      b.we  = we;
      b.dat = we ? wd[i] : 32'h0;
      exp_beat.push_back(b);
    end
    wait_ready(400);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_mask = mask;
    @(negedge clk_i);
    req_valid = 1'b0;
    $display("req we=%0d addr=%08h len=%0d mask=%h beats=%0d", we, addr, len, mask, n);
    check("req_ready_low_after_accept", 64'(req_ready), 64'd0);
    check("cyc_high_after_accept", 64'(wb_cyc_o), 64'd1);
    if (we && send_data && gap > 0) check("stb_low_wfifo_empty", 64'(wb_stb_o), 64'd0);
    if (we && send_data) begin
      for (int i = 0; i < n; i++) begin
        repeat (gap) @(negedge clk_i);
        write_valid = 1'b1; write_data = wd[i];
        @(negedge clk_i);
        write_valid = 1'b0;
      end
    end
  endtask

  // Slave: decides ack/err 2ns after each rising edge so the monitor sees stable values at negedge.
  initial begin : slave
    int wait_cnt, dly, beat_idx;
    bit do_err;
    wait_cnt = 0; dly = 0; beat_idx = 0;
    forever begin
      @(posedge clk_i); #2;
      if (wb_ack_i || wb_err_i) beat_idx++;
      if (!wb_cyc_o) beat_idx = 0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      if (wb_cyc_o && wb_stb_o && slave_mute == 0) begin
        if (wait_cnt >= dly) begin
          do_err = (beat_idx == slave_err_beat) || ($urandom_range(99) < slave_err_pct);
          if (do_err) begin
            wb_err_i = 1'b1;
            wb_ack_i = (slave_err_beat < 0) && ($urandom_range(3) == 0);
          end else begin
            wb_ack_i = 1'b1;
          end
          if (wb_ack_i) wb_dat_i = mem_word(wb_adr_o);
          wait_cnt = 0;
          dly = (slave_delay >= 0) ? slave_delay : $urandom_range(3);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin : ack_driver
    forever begin
      @(posedge clk_i); #2;
      case (ack_mode)
        0:       read_ack = 1'b0;
        1:       read_ack = 1'b1;
        default: read_ack = 1'($urandom_range(1));
      endcase
    end
  end

  initial begin : monitor
    bit berr_due;
    beat_t b;
    berr_due = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (bus_err_o) seen_berr_total++;
        if (berr_due) check("bus_err_after_err_beat", 64'(bus_err_o), 64'd1);
        berr_due = 0;
        if (read_valid && read_ack) begin
          if (exp_rd.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read actual=%08h required=none", read_data);
          end else check("read_data", 64'(read_data), 64'(exp_rd.pop_front()));
        end
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
          if (exp_beat.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual=adr %0h required=none", wb_adr_o);
          end else begin
            b = exp_beat.pop_front();
            check("beat_adr", 64'(wb_adr_o), 64'(b.adr));
            check("beat_sel", 64'(wb_sel_o), 64'(b.sel));
            check("beat_we", 64'(wb_we_o), 64'(b.we));
            if (b.we) check("beat_wdata", 64'(wb_dat_o), 64'(b.dat));
            else      exp_rd.push_back(wb_ack_i ? mem_word(b.adr) : 32'hFFFF_FFFF);
          end
          if (!wb_ack_i) begin
            berr_due = 1;
            exp_berr_total++;
          end
        end
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  task automatic timeout_test();
    int stb_cycles = 0, k = 0;
    slave_mute = 1; ack_mode = 0;
    wait_ready(400);
    req_valid = 1'b1; req_we = 1'b0; req_len = 3'd1; req_mask = 4'hF; req_addr = 32'h80;
    @(negedge clk_i);
    req_valid = 1'b0;
    while (wb_cyc_o && k < 100) begin
      if (wb_stb_o) stb_cycles++;
      @(negedge clk_i);
      k++;
    end
    check("timeout_stb_cycles", 64'(stb_cycles), 64'd8);
    check("timeout_read_data", 64'(read_data), 64'hFFFF_FFFF);
    exp_rd.push_back(32'hFFFF_FFFF);
    exp_berr_total++;
    slave_mute = 0; ack_mode = 1;
  endtask
`endif

  initial begin : stimulus
    logic [31:0] nopre [4];
    logic [31:0] ovf_v [4];
    logic [31:0] v5;
    logic [2:0]  lens [6];
    int berr0;
    for (int i = 0; i < 4; i++) begin nopre[i] = '0; ovf_v[i] = $urandom; end
    v5 = $urandom;
    lens[0] = 3'd1; lens[1] = 3'd4; lens[2] = 3'd4; lens[3] = 3'd2; lens[4] = 3'd0; lens[5] = 3'd7;

    repeat (3) @(negedge clk_i);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_we", 64'(wb_we_o), 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_sel", 64'(wb_sel_o), 64'd0);
    check("rst_bus_err", 64'(bus_err_o), 64'd0);
    check("rst_read_valid", 64'(read_valid), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("req_ready_after_reset", 64'(req_ready), 64'd1);

    // Single read, slave waits 2 cycles.
    ack_mode = 0; slave_delay = 2;
    do_req(1'b0, 32'h0000_1004, 3'd1, 4'b1100, 0, 1'b1, nopre);
    wait_ready(100);
    check("len1_read_valid", 64'(read_valid), 64'd1);
    ack_mode = 1;
    repeat (3) @(negedge clk_i);
    check("len1_read_drained", 64'(read_valid), 64'd0);

    // Line read with read_ack held low fills the FIFO; a further read must stall on space.
    ack_mode = 0; slave_delay = -1;
    do_req(1'b0, 32'h2000_0008, 3'd4, 4'h0, 0, 1'b1, nopre);
    wait_ready(100);
    check("burst_read_valid", 64'(read_valid), 64'd1);
    do_req(1'b0, 32'h0000_0030, 3'd1, 4'hF, 0, 1'b1, nopre);
    repeat (6) @(negedge clk_i);
    check("rfifo_full_cyc", 64'(wb_cyc_o), 64'd1);
    check("rfifo_full_stb", 64'(wb_stb_o), 64'd0);
    ack_mode = 1;
    wait_ready(100);

    // Line write with widely spaced write beats.
    slave_delay = 0;
    do_req(1'b1, 32'h0000_0100, 3'd4, 4'h0, 3, 1'b1, nopre);
    wait_ready(100);

    // Error on the second beat of a read burst.
    slave_delay = -1; slave_err_beat = 1; berr0 = seen_berr_total;
    do_req(1'b0, 32'h0000_0040, 3'd4, 4'h0, 0, 1'b1, nopre);
    wait_ready(100);
    slave_err_beat = -1;
    repeat (2) @(negedge clk_i);
    check("err_beat_pulse_count", 64'(seen_berr_total - berr0), 64'd1);

    // Write FIFO overflow: five pushes with no write request active.
    berr0 = seen_berr_total;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("no_ovf_on_4th", 64'(bus_err_o), 64'd0);
      write_valid = 1'b1; write_data = (k < 4) ? ovf_v[k] : v5;
      @(negedge clk_i);
    end
    write_valid = 1'b0;
    check("ovf_on_5th", 64'(bus_err_o), 64'd1);
    exp_berr_total++;
    @(negedge clk_i);
    check("ovf_single_pulse", 64'(seen_berr_total - berr0), 64'd1);
    do_req(1'b1, 32'h0000_0200, 3'd4, 4'h0, 0, 1'b0, ovf_v);
    wait_ready(100);
    do_req(1'b1, 32'h0000_0210, 3'd1, 4'h3, 0, 1'b1, nopre);
    wait_ready(100);

`ifdef BRIDGE_TIMEOUT_EN
    timeout_test();
    wait_ready(100);
`endif

    // Randomised mix of lengths (including illegal ones), masks, directions and slave behaviour.
    ack_mode = 2; slave_err_pct = 10;
    for (int t = 0; t < 40; t++) begin
      do_req(1'($urandom_range(1)), $urandom, lens[$urandom_range(5)], 4'($urandom),
             $urandom_range(2), 1'b1, nopre);
    end
    wait_ready(400);
    slave_err_pct = 0; ack_mode = 1;
    repeat (20) @(negedge clk_i);

    check("beats_outstanding", 64'(exp_beat.size()), 64'd0);
    check("reads_outstanding", 64'(exp_rd.size()), 64'd0);
    check("bus_err_total", 64'(seen_berr_total), 64'(exp_berr_total));
    check("final_read_valid", 64'(read_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
